// File: rtl/reorder_buffer.sv
// In-order reorder buffer: one allocation per cycle, two completion ports, and at most one
// in-order retire per cycle that frees the previous physical tag. Optional ROB_PERF_EN adds retired_count.
module reorder_buffer #(
  parameter int PREG_WIDTH = 6,
  parameter int AREG_WIDTH = 5,
  parameter int DEPTH      = 16,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic                  alloc_reg_write,
  input  logic [AREG_WIDTH-1:0] alloc_rd,
  input  logic [PREG_WIDTH-1:0] alloc_prd,
  input  logic [PREG_WIDTH-1:0] alloc_old_prd,
  input  logic [11:0]           alloc_pc,
  output logic                  alloc_ready,
  output logic [IDX_WIDTH-1:0]  alloc_idx,
  input  logic                  cmpl0_valid,
  input  logic [IDX_WIDTH-1:0]  cmpl0_idx,
  input  logic                  cmpl1_valid,
  input  logic [IDX_WIDTH-1:0]  cmpl1_idx,
  output logic                  retire_valid,
  output logic [AREG_WIDTH-1:0] retire_rd,
  output logic [PREG_WIDTH-1:0] retire_prd,
  output logic [11:0]           retire_pc,
  output logic                  free_push,
  output logic [PREG_WIDTH-1:0] free_reg,
`ifdef ROB_PERF_EN
  output logic [31:0]           retired_count,
`endif
  output logic [IDX_WIDTH:0]    count,
  output logic                  empty,
  output logic                  full
);

  logic [IDX_WIDTH:0]    head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]      valid_q, valid_d, done_q, done_d;
  logic                  ent_rw_q  [DEPTH];
  logic [AREG_WIDTH-1:0] ent_rd_q  [DEPTH];
  logic [PREG_WIDTH-1:0] ent_prd_q [DEPTH];
  logic [PREG_WIDTH-1:0] ent_old_q [DEPTH];
  logic [11:0]           ent_pc_q  [DEPTH];
  logic [IDX_WIDTH-1:0]  head_idx, tail_idx;
  logic                  do_alloc, do_retire;

  logic                  retire_valid_q, free_push_q;
  logic [AREG_WIDTH-1:0] retire_rd_q;
  logic [PREG_WIDTH-1:0] retire_prd_q, free_reg_q;
  logic [11:0]           retire_pc_q;

  // Status is derived from registered pointers only; the wrap bit separates full from empty.
  assign head_idx    = head_q[IDX_WIDTH-1:0];
  assign tail_idx    = tail_q[IDX_WIDTH-1:0];
  assign empty       = (head_q == tail_q);
  assign full        = (head_idx == tail_idx) && (head_q[IDX_WIDTH] != tail_q[IDX_WIDTH]);
  assign count       = tail_q - head_q;
  assign alloc_ready = !full;
  assign alloc_idx   = tail_idx;
  assign do_alloc    = alloc_valid && !full;
  assign do_retire   = valid_q[head_idx] && done_q[head_idx];

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    // Completions only land on entries that were already valid before this edge.
    if (cmpl0_valid && valid_q[cmpl0_idx]) done_d[cmpl0_idx] = 1'b1;
    if (cmpl1_valid && valid_q[cmpl1_idx]) done_d[cmpl1_idx] = 1'b1;
    if (do_retire) begin
      valid_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
      head_d            = head_q + {{IDX_WIDTH{1'b0}}, 1'b1};
    end
    if (do_alloc) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
      tail_d            = tail_q + {{IDX_WIDTH{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc) begin
      ent_rw_q[tail_idx]  <= alloc_reg_write;
      ent_rd_q[tail_idx]  <= alloc_rd;
      ent_prd_q[tail_idx] <= alloc_prd;
      ent_old_q[tail_idx] <= alloc_old_prd;
      ent_pc_q[tail_idx]  <= alloc_pc;
    end
  end

  // Retire outputs pulse for one cycle; data holds between retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_valid_q <= 1'b0;
      free_push_q    <= 1'b0;
      retire_rd_q    <= '0;
      retire_prd_q   <= '0;
      retire_pc_q    <= '0;
      free_reg_q     <= '0;
    end else begin
      retire_valid_q <= do_retire;
      free_push_q    <= do_retire && ent_rw_q[head_idx] && (ent_old_q[head_idx] != '0);
      if (do_retire) begin
        retire_rd_q  <= ent_rd_q[head_idx];
        retire_prd_q <= ent_prd_q[head_idx];
        retire_pc_q  <= ent_pc_q[head_idx];
        free_reg_q   <= ent_old_q[head_idx];
      end
    end
  end

  assign retire_valid = retire_valid_q;
  assign free_push    = free_push_q;
  assign retire_rd    = retire_rd_q;
  assign retire_prd   = retire_prd_q;
  assign retire_pc    = retire_pc_q;
  assign free_reg     = free_reg_q;

`ifdef ROB_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else if (retire_valid_q) perf_q <= perf_q + 32'd1;
  end

  assign retired_count = perf_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer against a queue-based reference model.
module tb_reorder_buffer;
  localparam int PREG_WIDTH = 6;
  localparam int AREG_WIDTH = 5;
  localparam int DEPTH      = 16;
  localparam int IDX_WIDTH  = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  alloc_valid = 1'b0, alloc_reg_write = 1'b0;
  logic [AREG_WIDTH-1:0] alloc_rd = '0;
  logic [PREG_WIDTH-1:0] alloc_prd = '0, alloc_old_prd = '0;
  logic [11:0]           alloc_pc = '0;
  logic                  alloc_ready;
  logic [IDX_WIDTH-1:0]  alloc_idx;
  logic                  cmpl0_valid = 1'b0, cmpl1_valid = 1'b0;
  logic [IDX_WIDTH-1:0]  cmpl0_idx = '0, cmpl1_idx = '0;
  logic                  retire_valid, free_push, empty, full;
  logic [AREG_WIDTH-1:0] retire_rd;
  logic [PREG_WIDTH-1:0] retire_prd, free_reg;
  logic [11:0]           retire_pc;
  logic [IDX_WIDTH:0]    count;
`ifdef ROB_PERF_EN
  logic [31:0]           retired_count;
`endif

  reorder_buffer #(.PREG_WIDTH(PREG_WIDTH), .AREG_WIDTH(AREG_WIDTH), .DEPTH(DEPTH),
                   .IDX_WIDTH(IDX_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_reg_write(alloc_reg_write), .alloc_rd(alloc_rd),
    .alloc_prd(alloc_prd), .alloc_old_prd(alloc_old_prd), .alloc_pc(alloc_pc),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .cmpl0_valid(cmpl0_valid), .cmpl0_idx(cmpl0_idx),
    .cmpl1_valid(cmpl1_valid), .cmpl1_idx(cmpl1_idx),
    .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_prd(retire_prd),
    .retire_pc(retire_pc), .free_push(free_push), .free_reg(free_reg),
`ifdef ROB_PERF_EN
    .retired_count(retired_count),
`endif
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rw;
    bit [4:0]  rd;
    bit [5:0]  prd;
    bit [5:0]  old;
    bit [11:0] pc;
    bit        done;
  } ent_t;

  ent_t      mq[$];
  int        m_head = 0;
  bit        e_rv = 0, e_fp = 0;
  bit [4:0]  e_rd = 0;
  bit [5:0]  e_prd = 0, e_fr = 0;
  bit [11:0] e_pc = 0;
  int        e_perf = 0;
  int        n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mark_done(input int idx);
    for (int i = 0; i < mq.size(); i++)
      if ((m_head + i) % DEPTH == idx) mq[i].done = 1'b1;
  endtask

  // Advance one clock: update the model with the inputs driven for this edge, then compare.
  task automatic tick();
    bit   m_full, m_ret;
    ent_t h, n;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_head = 0;
      e_rv = 0; e_fp = 0; e_rd = 0; e_prd = 0; e_fr = 0; e_pc = 0; e_perf = 0;
    end else begin
      m_full = (mq.size() == DEPTH);
      m_ret  = (mq.size() > 0) && mq[0].done;
      if (e_rv) e_perf++;
      if (cmpl0_valid) mark_done(int'(cmpl0_idx));
      if (cmpl1_valid) mark_done(int'(cmpl1_idx));
      e_rv = m_ret;
      e_fp = 1'b0;
      if (m_ret) begin
        h = mq.pop_front();
        m_head = (m_head + 1) % DEPTH;
        e_fp = h.rw && (h.old != 0);
        e_fr = h.old; e_rd = h.rd; e_prd = h.prd; e_pc = h.pc;
      end
      if (alloc_valid && !m_full) begin
        n.rw = alloc_reg_write; n.rd = alloc_rd; n.prd = alloc_prd;
        n.old = alloc_old_prd; n.pc = alloc_pc; n.done = 1'b0;
        mq.push_back(n);
      end
    end
    #1;
    check("count", 32'(count), 32'(mq.size()));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("alloc_ready", 32'(alloc_ready), 32'(mq.size() != DEPTH));
    check("alloc_idx", 32'(alloc_idx), 32'((m_head + mq.size()) % DEPTH));
    check("retire_valid", 32'(retire_valid), 32'(e_rv));
    check("free_push", 32'(free_push), 32'(e_fp));
    check("free_reg", 32'(free_reg), 32'(e_fr));
    check("retire_rd", 32'(retire_rd), 32'(e_rd));
    check("retire_prd", 32'(retire_prd), 32'(e_prd));
    check("retire_pc", 32'(retire_pc), 32'(e_pc));
`ifdef ROB_PERF_EN
    check("retired_count", retired_count, 32'(e_perf));
`endif
  endtask

  task automatic idle();
    alloc_valid = 0; cmpl0_valid = 0; cmpl1_valid = 0; rst = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic alloc(input bit rw, input int rd, input int prd, input int old, input int pc);
    idle();
    alloc_valid = 1; alloc_reg_write = rw; alloc_rd = 5'(rd);
    alloc_prd = 6'(prd); alloc_old_prd = 6'(old); alloc_pc = 12'(pc);
    tick();
    alloc_valid = 0;
  endtask

  task automatic cmpl(input bit v0, input int i0, input bit v1, input int i1);
    idle();
    cmpl0_valid = v0; cmpl0_idx = 4'(i0); cmpl1_valid = v1; cmpl1_idx = 4'(i1);
    tick();
    cmpl0_valid = 0; cmpl1_valid = 0;
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    idle_cycles(1);

    // In-order retire despite out-of-order completion
    alloc(1, 1, 33, 1, 12'h000);
    alloc(1, 2, 34, 2, 12'h004);
    alloc(1, 3, 35, 3, 12'h008);
    cmpl(1, 2, 0, 0);
    cmpl(1, 0, 0, 0);
    cmpl(1, 1, 0, 0);
    idle_cycles(4);

    // Fill to full, refused 17th allocation, then retire and wrap
    do_reset();
    for (int i = 0; i < 16; i++) alloc(1, i, 32 + i, i + 1, i * 4);
    alloc(1, 7, 50, 9, 12'h0ff);
    cmpl(1, 0, 0, 0);
    idle_cycles(1);
    alloc(1, 9, 60, 10, 12'h100);
    for (int i = 1; i < 16; i++) cmpl(1, i, 0, 0);
    cmpl(1, 0, 0, 0);
    idle_cycles(3);

    // No-destination and old_prd==0 entries do not free
    do_reset();
    alloc(0, 4, 40, 7, 12'h200);
    alloc(1, 5, 41, 0, 12'h204);
    cmpl(1, 0, 1, 1);
    idle_cycles(3);

    // Dual completion on one index, and completion of an invalid index
    alloc(1, 6, 42, 8, 12'h300);
    cmpl(1, 5, 1, 9);
    cmpl(1, 2, 1, 2);
    idle_cycles(3);

    // Empty + alloc + completion aimed at the new index in the same cycle
    idle();
    alloc_valid = 1; alloc_reg_write = 1; alloc_rd = 5'd1; alloc_prd = 6'd44;
    alloc_old_prd = 6'd11; alloc_pc = 12'h400;
    cmpl0_valid = 1; cmpl0_idx = alloc_idx;
    tick();
    idle_cycles(2);
    cmpl(1, 3, 0, 0);
    idle_cycles(2);

    // Reset with entries in flight, two of them completed
    do_reset();
    for (int i = 0; i < 5; i++) alloc(1, i, 20 + i, 5 + i, 12'h500 + i * 4);
    cmpl(1, 1, 1, 2);
    do_reset();
    idle_cycles(2);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst = ($urandom_range(0, 399) == 0);
      alloc_valid = ($urandom_range(0, 9) < 6);
      alloc_reg_write = ($urandom_range(0, 3) != 0);
      alloc_rd = 5'($urandom);
      alloc_prd = 6'($urandom);
      alloc_old_prd = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
      alloc_pc = 12'($urandom);
      cmpl0_valid = ($urandom_range(0, 1) == 1);
      cmpl1_valid = ($urandom_range(0, 2) == 1);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        cmpl0_idx = 4'((m_head + $urandom_range(0, mq.size() - 1)) % DEPTH);
      else
        cmpl0_idx = 4'($urandom);
      cmpl1_idx = ($urandom_range(0, 3) == 0) ? cmpl0_idx : 4'($urandom);
      tick();
    end
    idle();
    idle_cycles(2);

`ifdef ROB_PERF_EN
    // Exactly 20 retires from a clean reset
    do_reset();
    for (int i = 0; i < 20; i++) begin
      alloc(1, i, 30, 2, i);
      cmpl(1, m_head, 0, 0);
    end
    idle_cycles(3);
    check("retired_20", retired_count, 32'd20);
    do_reset();
    check("retired_rst", retired_count, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order reorder buffer for the out-of-order core, sitting between rename/dispatch and the free pool. It receives one renamed instruction per cycle from rename and marks entries complete from two functional-unit completion ports. Each cycle it retires at most one oldest completed instruction, returning that instruction's previous physical destination tag to the free pool (`free_push`/`free_reg`, wired to the free pool's `push`/`data_in`).

## Interface
- `PREG_WIDTH`, 6: physical register tag width
- `AREG_WIDTH`, 5: architectural register index width
- `DEPTH`, 16: number of entries (power of two)
- `IDX_WIDTH`, 4: log2(DEPTH)

Clock and reset (already decided): one clock; reset is synchronous and active-high.

- `clk` in 1: clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `alloc_valid` in 1: rename presents an instruction
- `alloc_reg_write` in 1: instruction writes rd
- `alloc_rd` in AREG_WIDTH: architectural destination
- `alloc_prd` in PREG_WIDTH: new physical destination tag
- `alloc_old_prd` in PREG_WIDTH: previous mapping of rd
- `alloc_pc` in 12: instruction PC
- `alloc_ready` out 1: equals !full
- `alloc_idx` out IDX_WIDTH: tail index; the entry an accepted allocation receives this cycle
- `cmpl0_valid`, `cmpl1_valid` in 1: FU completion strobes
- `cmpl0_idx`, `cmpl1_idx` in IDX_WIDTH: ROB index completing
- `retire_valid` out 1: one instruction retired (registered)
- `retire_rd` out AREG_WIDTH, `retire_prd` out PREG_WIDTH, `retire_pc` out 12: fields of the retired entry
- `free_push` out 1: push `free_reg` into the free pool
- `free_reg` out PREG_WIDTH: old tag being freed
- `count` out IDX_WIDTH+1: occupied entries
- `empty`, `full` out 1

## Operation
- Circular buffer with head/tail pointers of IDX_WIDTH+1 bits; the extra MSB is the wrap bit.
  - empty = (head == tail).
  - full = low bits equal and MSBs differ.
  - count = tail − head, modulo 2^(IDX_WIDTH+1).
- Per-entry state: valid, done, reg_write, rd, prd, old_prd, pc.
- Allocate when `alloc_valid && !full`:
  - Write all fields at tail, set valid=1 and done=0, tail+1.
  - When `full`, `alloc_valid` is ignored and no state changes.
- Complete on each `cmplN_valid`: set done at `cmplN_idx` only if that entry is valid; otherwise ignore.
  - Both ports may target the same index in one cycle; the result is the same as a single completion.
- Retire:
  - Condition: head entry valid && done.
  - Action: clear valid, head+1, and register the entry's fields onto the retire outputs for exactly one cycle.
  - Otherwise `retire_valid`=0 and the retire/free data outputs hold their last values.
- Free:
  - `free_push` = 1 in the retire cycle iff the entry's reg_write=1 and old_prd != 0. Physical reg 0 is never freed.
  - `free_reg` = old_prd.
  - An instruction with no destination retires with `free_push`=0.
- State machine: none beyond the pointers. Occupancy moves EMPTY → PARTIAL → FULL, with one alloc and one retire per cycle max.

## Timing
- Reset values:
  - head=tail=0, all valid/done=0.
  - `retire_valid`=0, `free_push`=0; `free_reg`, `retire_rd`, `retire_prd`, `retire_pc`=0.
  - `count`=0, `empty`=1, `full`=0, `alloc_ready`=1, `alloc_idx`=0.
- Reset mid-operation: every in-flight entry is discarded. No free pushes are issued for discarded entries.
- `alloc_ready`, `alloc_idx`, `full`, `empty` and `count` are combinational from registered pointers only. They never depend on same-cycle alloc or retire.
- Full + retire in the same cycle: allocation is still refused. The slot is usable the next cycle.
- Empty + alloc + completion to the new index in the same cycle: the completion is ignored (entry not yet valid).
- Latencies:
  - A completion sampled at edge N sets done at N.
  - The earliest retire is at edge N+1; outputs are visible after N+1 for one cycle.
  - Allocation to retire takes at least 2 edges.
- Simultaneous alloc and retire in one cycle: both occur and count is unchanged.
- Pointer wrap: index DEPTH−1 is followed by index 0, with the wrap bit toggled.

## Configuration
- Macro: `ROB_PERF_EN`.
- When defined:
  - Adds output `retired_count` [31:0], incremented on every `retire_valid`.
  - Wraps modulo 2^32; reset value 0.
- When undefined: the port and counter are absent, with no other behaviour change.

## Test plan
- Reset, then allocate PC 0x000/0x004/0x008 (prd 33/34/35, old 1/2/3), complete idx 2, 0, 1 on consecutive cycles → retires strictly in order PC 0x000, 0x004, 0x008, with `free_reg` 1, 2, 3.
- Allocate 16 entries with no completions → `full`=1, `alloc_ready`=0, `count`=16. A 17th `alloc_valid` → no change. Complete idx 0 → one retire, then `alloc_idx`=0 with wrap bit set.
- Entry with reg_write=0, and another with old_prd=0 → retires with `free_push`=0.
- Completing both ports on the same idx, and completing an invalid idx → single done, no spurious retire.
- Assert `rst` with 5 entries in flight, 2 of them completed → next cycle `empty`=1, `count`=0, no `retire_valid`/`free_push`.
- `ROB_PERF_EN` defined: retire 20 instructions → `retired_count`=20; after reset → 0.
